// File: rtl/fp_membrane_accumulator_if.sv
// Weight stream into the membrane accumulator: valid/ready handshake carrying
// one FP32 synaptic weight per transfer.
interface fp_membrane_accumulator_if;
   logic        in_valid;
   logic [31:0] in_weight;
   logic        in_ready;

   modport master (output in_valid, output in_weight, input in_ready);
   modport slave  (input in_valid, input in_weight, output in_ready);
endinterface

// File: rtl/fp_membrane_accumulator.sv
// LIF neuron front end: accumulates FP32 weights into a membrane potential
// through an external combinational FP32 adder, and on each timestep boundary
// fires a one-cycle spike when potential >= THRESHOLD, then resets it.
// Build option: define FP_LEAK_EN to subtract LEAK from the potential before
// every threshold check.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | accept a weight, or serve a step boundary (step_end/pending)
// S_ADD   | potential += weight_q via the adder
// S_LEAK  | potential -= LEAK via the adder (FP_LEAK_EN builds only)
// S_CHECK | compare against THRESHOLD, fire and reset on success
module fp_membrane_accumulator #(
   parameter logic [31:0] THRESHOLD = 32'h40A00000,
   parameter logic [31:0] V_RESET   = 32'h00000000,
   parameter logic [31:0] LEAK      = 32'h3F800000
) (
   input  logic                            CLK,
   input  logic                            RESET_N,
   fp_membrane_accumulator_if.slave        w_if,
   input  logic                            step_end,
   output logic [31:0]                     add_a,
   output logic [31:0]                     add_b,
   output logic                            add_sub,
   input  logic [31:0]                     add_result,
   input  logic                            add_exception,
   output logic [31:0]                     potential,
   output logic                            spike_out,
   output logic                            err_flag
);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_LEAK, S_CHECK} state_t;

   state_t      state_q, state_d;
   logic [31:0] potential_q, potential_d;
   logic [31:0] weight_q, weight_d;
   logic        pending_q, pending_d;
   logic        spike_q, spike_d;
   logic        err_q, err_d;
   logic        in_ready_c;
   logic        fire;

   // IEEE ordering for a >= b: NaN never compares true, -0 equals +0.
   function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
      logic a_nan, b_nan;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan || b_nan)                         return 1'b0;
      if (a[30:0] == 31'd0 && b[30:0] == 31'd0)   return 1'b1;
      if (a[31] != b[31])                         return ~a[31];
      if (!a[31])                                 return a[30:0] >= b[30:0];
      return a[30:0] <= b[30:0];
   endfunction

`ifndef FP_LEAK_EN
   // LEAK only matters when the leak step is built in.
   logic unused_leak;
   assign unused_leak = ^LEAK;
`endif

   assign fire = fp_ge(potential_q, THRESHOLD);

   // Next-state, adder operand selection and handshake for the sequencer.
   always_comb begin
      state_d     = state_q;
      potential_d = potential_q;
      weight_d    = weight_q;
      spike_d     = 1'b0;
      err_d       = err_q;
      add_b       = 32'h0;
      add_sub     = 1'b0;
      in_ready_c  = 1'b0;
      // A boundary seen while busy is remembered; IDLE always consumes it.
      pending_d   = (state_q == S_IDLE) ? 1'b0 : (pending_q | step_end);
      case (state_q)
         S_IDLE: begin
            in_ready_c = ~(step_end | pending_q);
            if (step_end | pending_q) begin
`ifdef FP_LEAK_EN
               state_d = S_LEAK;
`else
               state_d = S_CHECK;
`endif
            end else if (w_if.in_valid) begin
               weight_d = w_if.in_weight;
               state_d  = S_ADD;
            end
         end
         S_ADD: begin
            add_b = weight_q;
            if (add_exception) err_d = 1'b1;
            else               potential_d = add_result;
            state_d = S_IDLE;
         end
`ifdef FP_LEAK_EN
         S_LEAK: begin
            add_b   = LEAK;
            add_sub = 1'b1;
            if (add_exception) err_d = 1'b1;
            else               potential_d = add_result;
            state_d = S_CHECK;
         end
`endif
         S_CHECK: begin
            if (fire) begin
               potential_d = V_RESET;
               spike_d     = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset drops any in-flight add.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         potential_q <= V_RESET;
         weight_q    <= 32'h0;
         pending_q   <= 1'b0;
         spike_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         potential_q <= potential_d;
         weight_q    <= weight_d;
         pending_q   <= pending_d;
         spike_q     <= spike_d;
         err_q       <= err_d;
      end
   end

   assign w_if.in_ready = in_ready_c;
   assign add_a         = potential_q;
   assign potential     = potential_q;
   assign spike_out     = spike_q;
   assign err_flag      = err_q;

endmodule
